// File: rtl/bnn_ctrl_pkg.sv
// Shared types and default sizes for the binarized-network sequencer.
package bnn_ctrl_pkg;
  localparam int N_CLASS = 10;
  localparam int SCORE_W = 5;
  localparam int CLASS_W = $clog2(N_CLASS);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    ARGMAX,
    DONE
  } state_t;
endpackage

// File: rtl/bnn_argmax_seq.sv
// Serial max-reduction over captured class scores, one class per step.
module bnn_argmax_seq #(
  parameter int N_CLASS = bnn_ctrl_pkg::N_CLASS,
  parameter int SCORE_W = bnn_ctrl_pkg::SCORE_W,
  parameter int CLASS_W = bnn_ctrl_pkg::CLASS_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       init_i,
  input  logic                       step_i,
  input  logic [SCORE_W-1:0]         init_score_i,
  input  logic [N_CLASS*SCORE_W-1:0] scores_i,
  output logic                       last_o,
  output logic [CLASS_W-1:0]         best_idx_d_o,
  output logic [SCORE_W-1:0]         best_score_d_o
);
  logic [CLASS_W-1:0] idx_q;
  logic [CLASS_W-1:0] best_idx_q;
  logic [CLASS_W-1:0] best_idx_d;
  logic [SCORE_W-1:0] best_score_q;
  logic [SCORE_W-1:0] best_score_d;
  logic [SCORE_W-1:0] cur_score;

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    cur_score    = scores_i[idx_q*SCORE_W +: SCORE_W];
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    if (step_i && (cur_score > best_score_q)) begin
      best_idx_d   = idx_q;
      best_score_d = cur_score;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else if (init_i) begin
      idx_q        <= CLASS_W'(1);
      best_idx_q   <= '0;
      best_score_q <= init_score_i;
    end else if (step_i) begin
      idx_q        <= idx_q + CLASS_W'(1);
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
    end
  end

  assign last_o         = (idx_q == CLASS_W'(N_CLASS - 1));
  assign best_idx_d_o   = best_idx_d;
  assign best_score_d_o = best_score_d;
endmodule

// File: rtl/bnn_seq_ctrl.sv
// Inference sequencer: latch image, hold it for a settle window, capture
// the class scores and reduce them serially to the winning class.
module bnn_seq_ctrl #(
  parameter int N_CLASS    = bnn_ctrl_pkg::N_CLASS,
  parameter int SCORE_W    = bnn_ctrl_pkg::SCORE_W,
  parameter int IMG_BITS   = 64,
  parameter int SETTLE_CYC = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [IMG_BITS-1:0]        image_i,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       trigger_o,
  output logic [IMG_BITS-1:0]        net_image_o,
  input  logic [N_CLASS*SCORE_W-1:0] net_scores_i,
  output logic [N_CLASS*SCORE_W-1:0] scores_o,
  output logic                       done_o,
  output logic [$clog2(N_CLASS)-1:0] class_o,
  output logic [SCORE_W-1:0]         score_o
);
  import bnn_ctrl_pkg::*;

  localparam int CLS_W = $clog2(N_CLASS);

  if ((SETTLE_CYC < 1) || (SETTLE_CYC > 255) || (N_CLASS < 2)) begin : g_param_check
    $error("bnn_seq_ctrl: SETTLE_CYC must be 1..255 and N_CLASS >= 2");
  end

  // Handshake: start_i is honoured only while ready_o is high (IDLE); done_o
  // pulses for exactly one cycle with class_o/score_o/scores_o already valid.
  state_t             state_q;
  logic [7:0]         settle_q;
  logic               am_init;
  logic               am_step;
  logic               am_last;
  logic [CLS_W-1:0]   am_idx_d;
  logic [SCORE_W-1:0] am_score_d;

  assign am_init = (state_q == CAPTURE);
  assign am_step = (state_q == ARGMAX);

  bnn_argmax_seq #(
    .N_CLASS (N_CLASS),
    .SCORE_W (SCORE_W),
    .CLASS_W (CLS_W)
  ) u_argmax (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .init_i         (am_init),
    .step_i         (am_step),
    .init_score_i   (net_scores_i[SCORE_W-1:0]),
    .scores_i       (scores_o),
    .last_o         (am_last),
    .best_idx_d_o   (am_idx_d),
    .best_score_d_o (am_score_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      ready_o     <= 1'b1;
      busy_o      <= 1'b0;
      trigger_o   <= 1'b0;
      done_o      <= 1'b0;
      net_image_o <= '0;
      scores_o    <= '0;
      class_o     <= '0;
      score_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            net_image_o <= image_i;
            settle_q    <= 8'(SETTLE_CYC - 1);
            state_q     <= SETTLE;
            ready_o     <= 1'b0;
            busy_o      <= 1'b1;
            trigger_o   <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q <= CAPTURE;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        CAPTURE: begin
          scores_o  <= net_scores_i;
          trigger_o <= 1'b0;
          state_q   <= ARGMAX;
        end
        ARGMAX: begin
          // The final step's result is taken straight from the reducer's next value.
          if (am_last) begin
            class_o <= am_idx_d;
            score_o <= am_score_d;
            done_o  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Self-checking bench for bnn_seq_ctrl: vector table, random runs against a
// reference argmax, and hand-written multi-cycle corner cases.
module tb_bnn_seq_ctrl;
  localparam int N_CLASS  = 10;
  localparam int SCORE_W  = 5;
  localparam int IMG_BITS = 64;
  localparam int SW       = N_CLASS * SCORE_W;
  // done_o is visible after the 14th edge following the start edge
  // (DONE occupies cycle k+SETTLE_CYC+N_CLASS+1 when SETTLE occupies k+1..).
  localparam int LAT0 = 4 + N_CLASS;
  localparam int LAT1 = 1 + N_CLASS;

  typedef int arr_t[N_CLASS];
  typedef struct {
    logic [IMG_BITS-1:0] img;
    logic [SW-1:0]       sc;
    logic [3:0]          exp_class;
    logic [4:0]          exp_score;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                start, ready, busy, trigger, done;
  logic [IMG_BITS-1:0] image, net_image;
  logic [SW-1:0]       net_scores, scores;
  logic [3:0]          class_v;
  logic [4:0]          score_v;

  logic                start1, ready1, busy1, trigger1, done1;
  logic [IMG_BITS-1:0] image1, net_image1;
  logic [SW-1:0]       net_scores1, scores1;
  logic [3:0]          class1;
  logic [4:0]          score1;

  bnn_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .image_i(image),
    .ready_o(ready), .busy_o(busy), .trigger_o(trigger), .net_image_o(net_image),
    .net_scores_i(net_scores), .scores_o(scores), .done_o(done),
    .class_o(class_v), .score_o(score_v)
  );

  bnn_seq_ctrl #(.SETTLE_CYC(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .image_i(image1),
    .ready_o(ready1), .busy_o(busy1), .trigger_o(trigger1), .net_image_o(net_image1),
    .net_scores_i(net_scores1), .scores_o(scores1), .done_o(done1),
    .class_o(class1), .score_o(score1)
  );

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];
  vec_t tbl[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] pack(input arr_t s);
    logic [SW-1:0] r;
    r = '0;
    for (int c = 0; c < N_CLASS; c++) r[c*SCORE_W +: SCORE_W] = SCORE_W'(s[c]);
    return r;
  endfunction

  // Reference: find the maximum value, then the first class holding it.
  function automatic logic [8:0] ref_argmax(input logic [SW-1:0] sc);
    int vals[$];
    int mx[$];
    int idx[$];
    for (int c = 0; c < N_CLASS; c++) vals.push_back(int'(sc[c*SCORE_W +: SCORE_W]));
    mx  = vals.max();
    idx = vals.find_first_index with (item == mx[0]);
    return {4'(idx[0]), 5'(mx[0])};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 64'(ready), 1);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_trigger"}, 64'(trigger), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_net_image"}, net_image, 0);
    check({tag, "_scores"}, 64'(scores), 0);
    check({tag, "_class"}, 64'(class_v), 0);
    check({tag, "_score"}, 64'(score_v), 0);
  endtask

  task automatic run_one(input logic [IMG_BITS-1:0] img, input logic [SW-1:0] sc,
                         input logic [8:0] exp, input int glitch_at);
    int lat;
    int trig;
    int dones;
    logic [8:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    image = img; net_scores = sc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", 64'(busy), 1);
    check("accept_ready", 64'(ready), 0);
    check("accept_image", net_image, img);
    trig = trigger ? 1 : 0;
    lat = 0;
    while (!done && lat < 40) begin
      start = (glitch_at > 0) && (lat == glitch_at);
      if (start) image = ~img;
      @(negedge clk);
      lat++;
      if (trigger) trig++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check("done_latency", lat, LAT0);
    check("trigger_cycles", trig, 5);
    check("class", 64'(class_v), 64'(e[8:5]));
    check("score", 64'(score_v), 64'(e[4:0]));
    check("scores_o", 64'(scores), 64'(sc));
    check("net_image_hold", net_image, img);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("done_one_cycle", 64'(done), 0);
        check("ready_after_done", 64'(ready), 1);
      end
      if (done) dones++;
    end
    check("extra_done", dones, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, trig, dones, last, nd, rdy;
    logic [SW-1:0] sa, sb;
    logic [8:0] e;

    start = 0; image = '0; net_scores = '0;
    start1 = 0; image1 = '0; net_scores1 = '0;

    tbl[0] = '{64'hA5A5_A5A5_5A5A_5A5A, pack('{3,7,2,9,1,0,9,4,5,6}), 4'd3, 5'd9};
    tbl[1] = '{64'h0123_4567_89AB_CDEF, pack('{17,17,17,17,17,17,17,17,17,17}), 4'd0, 5'd17};
    tbl[2] = '{64'hFFFF_0000_FFFF_0000, pack('{0,0,0,0,0,0,0,0,0,0}), 4'd0, 5'd0};
    tbl[3] = '{64'h8000_0000_0000_0001, pack('{1,2,3,4,5,6,7,8,9,31}), 4'd9, 5'd31};
    tbl[4] = '{64'hDEAD_BEEF_CAFE_F00D, pack('{5,5,5,5,5,5,5,5,30,30}), 4'd8, 5'd30};

    #12;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_reset");

    for (int i = 0; i < 5; i++)
      run_one(tbl[i].img, tbl[i].sc, {tbl[i].exp_class, tbl[i].exp_score}, 0);

    // Start while busy must be dropped.
    run_one(64'h1111_2222_3333_4444, pack('{4,4,8,1,0,8,2,3,3,3}), {4'd2, 5'd8}, 5);

    for (int i = 0; i < 16; i++) begin
      logic [SW-1:0] rs;
      logic [IMG_BITS-1:0] ri;
      int hi;
      hi = (i % 2 == 0) ? 31 : 3;
      rs = '0;
      for (int c = 0; c < N_CLASS; c++) rs[c*SCORE_W +: SCORE_W] = SCORE_W'($urandom_range(0, hi));
      ri = {$urandom(), $urandom()};
      run_one(ri, rs, ref_argmax(rs), 0);
    end

    // Held start: back-to-back runs every 16 cycles with one ready cycle between.
    @(negedge clk);
    image = 64'h5555_AAAA_5555_AAAA;
    net_scores = pack('{1,1,1,1,1,1,1,1,1,2});
    start = 1'b1;
    last = -1; nd = 0; rdy = 0;
    for (int t = 1; t <= 52; t++) begin
      @(negedge clk);
      if (ready) rdy++;
      if (done) begin
        if (last >= 0) begin
          check("held_period", t - last, 16);
          check("held_ready_gap", rdy, 1);
        end
        check("held_class", 64'(class_v), 9);
        last = t; nd++; rdy = 0;
      end
    end
    check("held_done_count", nd, 3);
    start = 1'b0;
    lat = 0;
    while (!ready && lat < 40) begin @(negedge clk); lat++; end
    check("held_drain", 64'(ready), 1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    image = 64'h0F0F_0F0F_0F0F_0F0F; net_scores = pack('{9,8,7,6,5,4,3,2,1,0}); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("aborted_no_done", dones, 0);
    run_one(64'h0F0F_0F0F_0F0F_0F0F, pack('{9,8,7,6,5,4,3,2,1,0}), {4'd0, 5'd9}, 0);

    // SETTLE_CYC=1 instance; scores change after the capture edge.
    sa = pack('{1,2,30,4,5,6,7,8,9,10});
    sb = pack('{31,31,31,31,31,31,31,31,31,31});
    e = ref_argmax(sa);
    @(negedge clk);
    image1 = 64'hC3C3_3C3C_C3C3_3C3C; net_scores1 = sa; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    trig = trigger1 ? 1 : 0;
    lat = 0;
    while (!done1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) net_scores1 = sb;
      if (trigger1) trig++;
    end
    check("s1_latency", lat, LAT1);
    check("s1_trigger_cycles", trig, 2);
    check("s1_class", 64'(class1), 64'(e[8:5]));
    check("s1_score", 64'(score1), 64'(e[4:0]));
    check("s1_scores_o", 64'(scores1), 64'(sa));
    check("s1_net_image", net_image1, 64'hC3C3_3C3C_C3C3_3C3C);
    @(negedge clk);
    check("s1_done_pulse", 64'(done1), 0);
    check("s1_ready", 64'(ready1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bnn_seq_ctrl.md
# bnn_seq_ctrl

Sequencer wrapped around the combinational binarized network (conv→view→linear→last layer). Latches an 8×8 binary image, drives it into the network, waits a programmed settle window (multicycle path), captures the ten class scores, and reduces them serially to an argmax class. Provides the start/busy/done handshake and the capture trigger for the CW305 host interface.

## Interface
Parameters:
- N_CLASS, 10, number of class scores from the last layer
- SCORE_W, 5, width of one unsigned class score
- IMG_BITS, 64, binary image width (8×8×1)
- SETTLE_CYC, 4, cycles the network input is held stable before score capture; legal range 1..255

Ports:
- clk_i  in  1  single clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  request inference; sampled only in IDLE
- image_i  in  IMG_BITS  image, latched on the accepted start edge
- ready_o  out  1  high in IDLE
- busy_o  out  1  high in every state except IDLE
- trigger_o  out  1  high in SETTLE and CAPTURE (power-capture window)
- net_image_o  out  IMG_BITS  registered image driving the network input
- net_scores_i  in  N_CLASS×SCORE_W  network outputs, class c at bits [c*SCORE_W +: SCORE_W]
- scores_o  out  N_CLASS×SCORE_W  captured scores
- done_o  out  1  one-cycle pulse, result valid
- class_o  out  $clog2(N_CLASS)  winning class index
- score_o  out  SCORE_W  winning score

## Operation
- States: IDLE → SETTLE → CAPTURE → ARGMAX → DONE → IDLE.
- IDLE: ready_o=1. On start_i=1, net_image_o←image_i, settle counter←SETTLE_CYC−1, go SETTLE.
- SETTLE: counter decrements each cycle; leave for CAPTURE in the cycle the counter is 0.
- CAPTURE: scores_o←net_scores_i at the exiting edge; best index←0, best score←score[0], index counter←1.
- ARGMAX: one class per cycle, c = 1..N_CLASS−1; replace best only when score[c] > best (strict, unsigned), so ties resolve to the lowest index. Leave after c = N_CLASS−1.
- DONE: class_o/score_o←best, done_o=1 for this cycle only; next state IDLE.
- start_i while busy_o=1 is ignored (not queued); image_i is not sampled.
- net_image_o, scores_o, class_o, score_o hold their values until overwritten by the next inference.
- Argmax over all-equal scores → class 0.

## Timing
- Reset values: state IDLE, ready_o=1, busy_o=0, trigger_o=0, done_o=0, net_image_o=0, scores_o=0, class_o=0, score_o=0, counters 0.
- Start sampled at edge k: SETTLE occupies cycles k+1..k+SETTLE_CYC, CAPTURE k+SETTLE_CYC+1, ARGMAX the next N_CLASS−1 cycles, DONE at k+SETTLE_CYC+N_CLASS+1. Defaults: done_o high 15 cycles after the start edge.
- Earliest next start: the IDLE cycle following DONE (start_i held high produces back-to-back inferences with 1 idle cycle).
- net_image_o stable from k+1 through DONE; the network sees exactly SETTLE_CYC+1 stable cycles before capture (multicycle constraint SETTLE_CYC+1).
- rst_i asserted mid-inference: all outputs reach reset values immediately (asynchronous); no done_o pulse for the aborted run; first start after deassertion is honored normally.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package bnn_ctrl_pkg: state enum (IDLE, SETTLE, CAPTURE, ARGMAX, DONE), default localparams N_CLASS, SCORE_W, CLASS_W=$clog2(N_CLASS).
- Sub-module bnn_argmax_seq: serial max-reduction (init, step, index counter, best score/index); FSM in bnn_seq_ctrl drives init/step.
- Elaboration-time check: SETTLE_CYC in 1..255, N_CLASS ≥ 2.

## Test plan
- Basic: scores {3,7,2,9,1,0,9,4,5,6} stable, start with image 64'hA5A5_A5A5_5A5A_5A5A → done_o at start+15, class_o=3, score_o=9 (tie with class 6 → lowest), net_image_o equals image.
- All-equal: every score 17 → class_o=0, score_o=17; all zero → class_o=0, score_o=0; max at class 9 score 31 → class_o=9.
- Start while busy: second start pulse at start+5 with different image → ignored, net_image_o unchanged, exactly one done_o.
- Held start: start_i=1 continuously → done_o pulses every 16 cycles, ready_o high one cycle between runs.
- Reset mid-run: rst_i at start+6 → all outputs to reset values same cycle, no done_o; subsequent start completes in 15 cycles.
- SETTLE_CYC=1: trigger_o high exactly 2 cycles, done_o at start+12; scores changed after capture edge do not alter scores_o/class_o.
